// File: rtl/lsu_mem_ctrl_pkg.sv
// Shared types and helpers for the memory-stage load/store controller.
package lsu_mem_ctrl_pkg;

  localparam int DATA_W = 32;

  typedef enum logic [3:0] {
    AM_LB   = 4'b0000,
    AM_LH   = 4'b0001,
    AM_LW   = 4'b0010,
    AM_LBU  = 4'b0011,
    AM_LHU  = 4'b0100,
    AM_SB   = 4'b0101,
    AM_SH   = 4'b0110,
    AM_SW   = 4'b0111,
    AM_NONE = 4'b1000
  } addr_mode_t;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_REQ  = 2'b01,
    S_WAIT = 2'b10,
    S_DONE = 2'b11
  } lsu_state_t;

  function automatic logic is_store(input addr_mode_t m);
    logic r;
    case (m)
      AM_SB, AM_SH, AM_SW: r = 1'b1;
      default:             r = 1'b0;
    endcase
    return r;
  endfunction

  function automatic logic is_misaligned(input addr_mode_t m, input logic [1:0] off);
    logic r;
    case (m)
      AM_LH, AM_LHU, AM_SH: r = off[0];
      AM_LW, AM_SW:         r = (off != 2'b00);
      default:              r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/lsu_mem_ctrl_lane_align.sv
// Store byte-enable/lane steering and load byte/half extraction with extension.
module lsu_mem_ctrl_lane_align
  import lsu_mem_ctrl_pkg::*;
(
  input  addr_mode_t        st_mode_i,
  input  logic [1:0]        st_off_i,
  input  logic [DATA_W-1:0] st_data_i,
  output logic [3:0]        st_be_o,
  output logic [DATA_W-1:0] st_wdata_o,
  input  addr_mode_t        ld_mode_i,
  input  logic [1:0]        ld_off_i,
  input  logic [DATA_W-1:0] ld_rdata_i,
  output logic [DATA_W-1:0] ld_data_o
);

  logic [DATA_W-1:0] ld_shift_s;
  logic [7:0]        ld_byte_s;
  logic [15:0]       ld_half_s;

  // Byte enables follow access size; only stores put data on the lanes.
  always_comb begin
    st_be_o    = 4'b0000;
    st_wdata_o = 32'h0000_0000;
    case (st_mode_i)
      AM_LB, AM_LBU: st_be_o = 4'b0001 << st_off_i;
      AM_LH, AM_LHU: st_be_o = 4'b0011 << st_off_i;
      AM_LW:         st_be_o = 4'b1111;
      AM_SB: begin
        st_be_o    = 4'b0001 << st_off_i;
        st_wdata_o = {4{st_data_i[7:0]}};
      end
      AM_SH: begin
        st_be_o    = 4'b0011 << st_off_i;
        st_wdata_o = {2{st_data_i[15:0]}};
      end
      AM_SW: begin
        st_be_o    = 4'b1111;
        st_wdata_o = st_data_i;
      end
      default: begin
        st_be_o    = 4'b0000;
        st_wdata_o = 32'h0000_0000;
      end
    endcase
  end

  // Pick the addressed byte/half out of the returned word and extend it.
  always_comb begin
    ld_shift_s = ld_rdata_i >> {ld_off_i, 3'b000};
    ld_byte_s  = ld_shift_s[7:0];
    ld_half_s  = ld_off_i[1] ? ld_rdata_i[31:16] : ld_rdata_i[15:0];
    case (ld_mode_i)
      AM_LB:   ld_data_o = {{24{ld_byte_s[7]}}, ld_byte_s};
      AM_LBU:  ld_data_o = {24'h00_0000, ld_byte_s};
      AM_LH:   ld_data_o = {{16{ld_half_s[15]}}, ld_half_s};
      AM_LHU:  ld_data_o = {16'h0000, ld_half_s};
      AM_LW:   ld_data_o = ld_rdata_i;
      default: ld_data_o = 32'h0000_0000;
    endcase
  end

endmodule

// File: rtl/lsu_mem_ctrl.sv
// M-stage load/store controller: request/wait/done handshake with the data
// memory, stall generation, misalignment drop and response timeout.
module lsu_mem_ctrl
  import lsu_mem_ctrl_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 64,
  parameter int CNT_W          = $clog2(TIMEOUT_CYCLES + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [3:0]        AddrModeM,
  input  logic [DATA_W-1:0] ALUResultM,
  input  logic [DATA_W-1:0] WriteDataM,
  output logic [DATA_W-1:0] ReadDataM,
  output logic              stallM,
  output logic              misalignM,
  output logic              timeoutM,
  output logic              mem_req,
  input  logic              mem_ready,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_addr,
  output logic [3:0]        mem_be,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_rvalid,
  input  logic [DATA_W-1:0] mem_rdata
);

  lsu_state_t        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d, cnt_inc_s;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              misalign_q, misalign_d;
  logic              timeout_q, timeout_d;
  logic              req_q, req_d;
  logic              we_q, we_d;
  logic [DATA_W-1:0] addr_q, addr_d;
  logic [3:0]        be_q, be_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  addr_mode_t        mode_q, mode_d;
  logic [1:0]        off_q, off_d;

  addr_mode_t        mode_in_s;
  logic              op_valid_s, op_mis_s, stall_s;
  logic [3:0]        st_be_s;
  logic [DATA_W-1:0] st_wdata_s, ld_data_s;

  // Non-memory encodings are mapped to AM_NONE so no out-of-range enum value exists.
  always_comb begin
    if (AddrModeM[3]) begin
      mode_in_s = AM_NONE;
    end else begin
      mode_in_s = addr_mode_t'(AddrModeM);
    end
    op_valid_s = ~AddrModeM[3];
    op_mis_s   = op_valid_s & is_misaligned(mode_in_s, ALUResultM[1:0]);
  end

  // Store lanes come from the live op; load extraction uses the captured op.
  lsu_mem_ctrl_lane_align u_lane_align (
    .st_mode_i  (mode_in_s),
    .st_off_i   (ALUResultM[1:0]),
    .st_data_i  (WriteDataM),
    .st_be_o    (st_be_s),
    .st_wdata_o (st_wdata_s),
    .ld_mode_i  (mode_q),
    .ld_off_i   (off_q),
    .ld_rdata_i (mem_rdata),
    .ld_data_o  (ld_data_s)
  );

  // Stall must rise in the same cycle the op is first seen, so it is decoded from state.
  always_comb begin
    case (state_q)
      S_IDLE:  stall_s = op_valid_s & ~op_mis_s;
      S_REQ:   stall_s = 1'b1;
      S_WAIT:  stall_s = 1'b1;
      default: stall_s = 1'b0;
    endcase
  end

  assign stallM = stall_s;

  // Next-state and next-output computation for the access handshake.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    rdata_d    = rdata_q;
    misalign_d = 1'b0;
    timeout_d  = 1'b0;
    req_d      = req_q;
    we_d       = we_q;
    addr_d     = addr_q;
    be_d       = be_q;
    wdata_d    = wdata_q;
    mode_d     = mode_q;
    off_d      = off_q;
    cnt_inc_s  = cnt_q + CNT_W'(1);
    case (state_q)
      S_IDLE: begin
        if (op_valid_s && !op_mis_s) begin
          state_d = S_REQ;
          req_d   = 1'b1;
          we_d    = is_store(mode_in_s);
          addr_d  = {ALUResultM[31:2], 2'b00};
          be_d    = st_be_s;
          wdata_d = st_wdata_s;
          mode_d  = mode_in_s;
          off_d   = ALUResultM[1:0];
          cnt_d   = '0;
        end else if (op_mis_s) begin
          misalign_d = 1'b1;
          rdata_d    = 32'h0000_0000;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_REQ: begin
        if (mem_ready) begin
          state_d = S_WAIT;
          req_d   = 1'b0;
        end else begin
          state_d = S_REQ;
        end
      end
      S_WAIT: begin
        cnt_d = cnt_inc_s;
        // A response in the final allowed cycle still wins over the timeout.
        if (mem_rvalid) begin
          state_d = S_DONE;
          cnt_d   = '0;
          if (!is_store(mode_q)) begin
            rdata_d = ld_data_s;
          end else begin
            rdata_d = rdata_q;
          end
        end else if (cnt_inc_s == CNT_W'(TIMEOUT_CYCLES)) begin
          state_d   = S_DONE;
          cnt_d     = '0;
          timeout_d = 1'b1;
          rdata_d   = 32'h0000_0000;
        end else begin
          state_d = S_WAIT;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
        req_d   = 1'b0;
        cnt_d   = '0;
      end
    endcase
  end

  // State and registered outputs; reset returns to IDLE and drops any request.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      rdata_q    <= 32'h0000_0000;
      misalign_q <= 1'b0;
      timeout_q  <= 1'b0;
      req_q      <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= 32'h0000_0000;
      be_q       <= 4'b0000;
      wdata_q    <= 32'h0000_0000;
      mode_q     <= AM_NONE;
      off_q      <= 2'b00;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      rdata_q    <= rdata_d;
      misalign_q <= misalign_d;
      timeout_q  <= timeout_d;
      req_q      <= req_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      be_q       <= be_d;
      wdata_q    <= wdata_d;
      mode_q     <= mode_d;
      off_q      <= off_d;
    end
  end

  assign ReadDataM = rdata_q;
  assign misalignM = misalign_q;
  assign timeoutM  = timeout_q;
  assign mem_req   = req_q;
  assign mem_we    = we_q;
  assign mem_addr  = addr_q;
  assign mem_be    = be_q;
  assign mem_wdata = wdata_q;

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Directed bench for lsu_mem_ctrl: load results are queued at issue and checked in DONE.
module tb_lsu_mem_ctrl;

  localparam logic [3:0] M_LB  = 4'b0000;
  localparam logic [3:0] M_LH  = 4'b0001;
  localparam logic [3:0] M_LW  = 4'b0010;
  localparam logic [3:0] M_LBU = 4'b0011;
  localparam logic [3:0] M_LHU = 4'b0100;
  localparam logic [3:0] M_SB  = 4'b0101;
  localparam logic [3:0] M_SH  = 4'b0110;
  localparam logic [3:0] M_NOP = 4'b1000;

  logic        clk;
  logic        rst;
  logic [3:0]  AddrModeM;
  logic [31:0] ALUResultM, WriteDataM, ReadDataM;
  logic        stallM, misalignM, timeoutM;
  logic        mem_req, mem_ready, mem_we, mem_rvalid;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_be;

  int vecs    = 0;
  int miscmp  = 0;
  logic [31:0] exp_q[$];

  lsu_mem_ctrl #(.TIMEOUT_CYCLES(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .AddrModeM  (AddrModeM),
    .ALUResultM (ALUResultM),
    .WriteDataM (WriteDataM),
    .ReadDataM  (ReadDataM),
    .stallM     (stallM),
    .misalignM  (misalignM),
    .timeoutM   (timeoutM),
    .mem_req    (mem_req),
    .mem_ready  (mem_ready),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_be     (mem_be),
    .mem_wdata  (mem_wdata),
    .mem_rvalid (mem_rvalid),
    .mem_rdata  (mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vecs++;
    assert (obs === exp) else begin
      miscmp++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One full access: issue, hold in REQ for ready_wait cycles, respond in WAIT cycle rsp_at (0 = never).
  task automatic do_access(input string tag, input logic [3:0] mode, input logic [31:0] addr,
                           input logic [31:0] wd, input logic [31:0] rdata,
                           input int ready_wait, input int rsp_at,
                           input logic [3:0] exp_be, input logic [31:0] exp_wdata, input logic exp_we,
                           input bit is_ld, input logic [31:0] exp_rd, input logic exp_to,
                           input int exp_wait, input int exp_stall);
    int stall_n;
    int m;
    logic [31:0] exp_v;
    @(negedge clk);
    AddrModeM  = mode;
    ALUResultM = addr;
    WriteDataM = wd;
    mem_rdata  = rdata;
    mem_ready  = 1'b0;
    mem_rvalid = 1'b0;
    #1;
    chk({tag, "_stall0"}, 32'(stallM), 32'd1);
    chk({tag, "_noreq0"}, 32'(mem_req), 32'd0);
    stall_n = (stallM === 1'b1) ? 1 : 0;
    if (is_ld) exp_q.push_back(exp_rd);
    @(negedge clk);
    for (int i = 0; i <= ready_wait; i++) begin
      chk({tag, "_req"},   32'(mem_req), 32'd1);
      chk({tag, "_we"},    32'(mem_we), 32'(exp_we));
      chk({tag, "_addr"},  mem_addr, {addr[31:2], 2'b00});
      chk({tag, "_be"},    32'(mem_be), 32'(exp_be));
      chk({tag, "_wdata"}, mem_wdata, exp_wdata);
      if (stallM === 1'b1) stall_n++;
      mem_ready = (i == ready_wait);
      @(negedge clk);
    end
    mem_ready = 1'b0;
    chk({tag, "_reqdrop"}, 32'(mem_req), 32'd0);
    m = 1;
    while (stallM === 1'b1 && m <= 20) begin
      stall_n++;
      mem_rvalid = (m == rsp_at);
      @(negedge clk);
      mem_rvalid = 1'b0;
      m++;
    end
    chk({tag, "_waitcyc"}, 32'(m - 1), 32'(exp_wait));
    chk({tag, "_stallcyc"}, 32'(stall_n), 32'(exp_stall));
    chk({tag, "_timeout"}, 32'(timeoutM), 32'(exp_to));
    if (is_ld) begin
      exp_v = exp_q.pop_front();
      chk({tag, "_rdata"}, ReadDataM, exp_v);
    end
    AddrModeM = M_NOP;
    @(negedge clk);
    chk({tag, "_idle_stall"}, 32'(stallM), 32'd0);
    chk({tag, "_idle_to"}, 32'(timeoutM), 32'd0);
  endtask

  initial begin
    rst        = 1'b1;
    AddrModeM  = M_NOP;
    ALUResultM = 32'h0;
    WriteDataM = 32'h0;
    mem_ready  = 1'b0;
    mem_rvalid = 1'b0;
    mem_rdata  = 32'h0;
    repeat (3) @(negedge clk);
    chk("rst_stall", 32'(stallM), 32'd0);
    chk("rst_req", 32'(mem_req), 32'd0);
    chk("rst_rd", ReadDataM, 32'h0);
    chk("rst_be", 32'(mem_be), 32'd0);
    chk("rst_we", 32'(mem_we), 32'd0);
    chk("rst_mis", 32'(misalignM), 32'd0);
    chk("rst_to", 32'(timeoutM), 32'd0);
    rst = 1'b0;

    //        tag    mode   addr          wdata         rdata        rw rsp be       wdata        we    ld rd            to  wt st
    do_access("lw",  M_LW,  32'h0000_0100, 32'h0,        32'hDEADBEEF, 0, 1, 4'b1111, 32'h0,       1'b0, 1, 32'hDEADBEEF, 1'b0, 1, 3);
    do_access("lb",  M_LB,  32'h0000_0203, 32'h0,        32'h8012_3456, 0, 1, 4'b1000, 32'h0,      1'b0, 1, 32'hFFFFFF80, 1'b0, 1, 3);
    do_access("lbu", M_LBU, 32'h0000_0203, 32'h0,        32'h8012_3456, 0, 1, 4'b1000, 32'h0,      1'b0, 1, 32'h0000_0080, 1'b0, 1, 3);
    do_access("lhu", M_LHU, 32'h0000_0202, 32'h0,        32'h8001_7777, 0, 1, 4'b1100, 32'h0,      1'b0, 1, 32'h0000_8001, 1'b0, 1, 3);
    do_access("lh",  M_LH,  32'h0000_0200, 32'h0,        32'h1111_F00D, 0, 2, 4'b0011, 32'h0,      1'b0, 1, 32'hFFFF_F00D, 1'b0, 2, 4);
    do_access("sh",  M_SH,  32'h0000_0306, 32'h1234ABCD, 32'h0,        5, 1, 4'b1100, 32'hABCDABCD, 1'b1, 0, 32'h0,       1'b0, 1, 8);
    do_access("sb",  M_SB,  32'h0000_0101, 32'h0000_00A5, 32'h0,       0, 1, 4'b0010, 32'hA5A5A5A5, 1'b1, 0, 32'h0,       1'b0, 1, 3);
    do_access("tmo", M_LW,  32'h0000_0500, 32'h0,        32'h7777_7777, 0, 0, 4'b1111, 32'h0,      1'b0, 1, 32'h0,        1'b1, 4, 6);
    do_access("rv4", M_LW,  32'h0000_0504, 32'h0,        32'h1357_9BDF, 0, 4, 4'b1111, 32'h0,      1'b0, 1, 32'h1357_9BDF, 1'b0, 4, 6);

    // Reset while waiting for a response, then a late response arrives.
    @(negedge clk);
    AddrModeM  = M_LW;
    ALUResultM = 32'h0000_0400;
    mem_rdata  = 32'h55AA_55AA;
    mem_ready  = 1'b1;
    @(negedge clk);
    chk("rstw_req", 32'(mem_req), 32'd1);
    @(negedge clk);
    mem_ready = 1'b0;
    chk("rstw_wait_stall", 32'(stallM), 32'd1);
    chk("rstw_wait_req", 32'(mem_req), 32'd0);
    rst       = 1'b1;
    AddrModeM = M_NOP;
    @(negedge clk);
    chk("rstw_stall", 32'(stallM), 32'd0);
    chk("rstw_req0", 32'(mem_req), 32'd0);
    chk("rstw_rd", ReadDataM, 32'h0);
    chk("rstw_be", 32'(mem_be), 32'd0);
    rst        = 1'b0;
    mem_rvalid = 1'b1;
    @(negedge clk);
    mem_rvalid = 1'b0;
    chk("late_rd", ReadDataM, 32'h0);
    chk("late_stall", 32'(stallM), 32'd0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("nop_req", 32'(mem_req), 32'd0);
      chk("nop_stall", 32'(stallM), 32'd0);
      chk("nop_to", 32'(timeoutM), 32'd0);
    end

    do_access("lw2", M_LW, 32'h0000_0600, 32'h0, 32'hCAFE_F00D, 0, 1, 4'b1111, 32'h0, 1'b0, 1, 32'hCAFE_F00D, 1'b0, 1, 3);

    // Misaligned word load is dropped without a request.
    @(negedge clk);
    AddrModeM  = M_LW;
    ALUResultM = 32'h0000_0102;
    #1;
    chk("mis_stall", 32'(stallM), 32'd0);
    @(negedge clk);
    AddrModeM = M_NOP;
    chk("mis_pulse", 32'(misalignM), 32'd1);
    chk("mis_req", 32'(mem_req), 32'd0);
    chk("mis_rd", ReadDataM, 32'h0);
    chk("mis_stall2", 32'(stallM), 32'd0);
    @(negedge clk);
    chk("mis_end", 32'(misalignM), 32'd0);
    chk("mis_req2", 32'(mem_req), 32'd0);
    chk("sb_empty", 32'(exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, miscmp);
    $finish;
  end

endmodule
